// File: rtl/dsp_result_reader_pkg.sv
// Shared types and helpers for the DSP result reader: FSM encoding, sync depth,
// and the EMIF word formatting functions.
package dsp_result_reader_pkg;

  localparam int EMIF_SYNC_STAGES = 2;
  localparam int EMIF_DATA_W      = 32;
  localparam int EXT_W            = 36;
  localparam int HOLD_W           = EXT_W - EMIF_DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_RAM   = 2'd2,
    ST_DRIVE = 2'd3
  } rd_state_e;

  function automatic logic [EMIF_DATA_W-1:0] sext_hold(input logic [HOLD_W-1:0] h);
    return {{(EMIF_DATA_W-HOLD_W){h[HOLD_W-1]}}, h};
  endfunction

  function automatic logic [EMIF_DATA_W-1:0] status_word(input logic [15:0] cnt,
                                                         input logic ovr,
                                                         input logic bank);
    return {cnt, 14'b0, ovr, bank};
  endfunction

endpackage

// File: rtl/dsp_result_reader_if.sv
// Engine write stream and EMIF read-side bus of the DSP result reader.
interface dsp_result_reader_if #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 36,
  parameter int EMIF_ADDR_W = 10
);
  logic                   Mem2_we_i;
  logic [ADDR_W-1:0]      Mem2_addrw_i;
  logic [DATA_W-1:0]      Mem2_data_i;
  logic                   WIP_flag_i;
  logic                   EMIF_cs_i;
  logic                   EMIF_oe_i;
  logic [EMIF_ADDR_W-1:0] EMIF_address_i;
  logic [31:0]            EMIF_data_o;
  logic                   EMIF_data_oe_o;

  modport slave (
    input  Mem2_we_i, Mem2_addrw_i, Mem2_data_i, WIP_flag_i,
    input  EMIF_cs_i, EMIF_oe_i, EMIF_address_i,
    output EMIF_data_o, EMIF_data_oe_o
  );

  modport master (
    output Mem2_we_i, Mem2_addrw_i, Mem2_data_i, WIP_flag_i,
    output EMIF_cs_i, EMIF_oe_i, EMIF_address_i,
    input  EMIF_data_o, EMIF_data_oe_o
  );
endinterface

// File: rtl/dsp_result_reader_result_bank_ram.sv
// Ping-pong result storage: simple dual-port RAM, address MSB selects the bank,
// registered read port. Contents are intentionally not reset.
module dsp_result_reader_result_bank_ram #(
  parameter int AW = 10,
  parameter int DW = 36
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  // write port and registered read port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/dsp_result_reader.sv
// EMIF read responder: captures engine results into the write bank, swaps banks on
// frame completion, and serves synchronised asynchronous EMIF reads from the frozen bank.
module dsp_result_reader
  import dsp_result_reader_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 36,
  parameter int EMIF_ADDR_W = ADDR_W + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  dsp_result_reader_if.slave  bus,
  output logic                bank_o,
  output logic [15:0]         frame_cnt_o,
  output logic                overrun_o
);

  localparam logic [EMIF_ADDR_W-1:0] STATUS_ADDR = {EMIF_ADDR_W{1'b1}};

  rd_state_e               state_q, state_d;
  logic                    wip_q;
  logic                    bank_q, bank_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    pend_q, pend_d;
  logic                    ovr_q, ovr_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic [31:0]             data_q, data_d;
  logic                    oe_q, oe_d;
  logic [EMIF_ADDR_W-1:0]  addr_lat_q, addr_lat_d;
  logic                    status_rd_q, status_rd_d;

  logic [EMIF_SYNC_STAGES-1:0] cs_sync_q;
  logic [EMIF_SYNC_STAGES-1:0] oe_sync_q;
  logic [EMIF_ADDR_W-1:0]      addr_sync_q [EMIF_SYNC_STAGES];

  logic                    fall_s, rise_s, rd_req_s, do_swap_s, ram_re_s;
  logic [EMIF_ADDR_W-1:0]  addr_s;
  logic [DATA_W-1:0]       ram_rdata_s;
  logic [EXT_W-1:0]        word_ext_s;

  assign fall_s     = wip_q & ~bus.WIP_flag_i;
  assign rise_s     = ~wip_q & bus.WIP_flag_i;
  assign rd_req_s   = ~cs_sync_q[EMIF_SYNC_STAGES-1] & ~oe_sync_q[EMIF_SYNC_STAGES-1];
  assign addr_s     = addr_sync_q[EMIF_SYNC_STAGES-1];
  assign do_swap_s  = pend_q & (state_q == ST_IDLE);
  assign word_ext_s = EXT_W'(signed'(ram_rdata_s));

  dsp_result_reader_result_bank_ram #(
    .AW (ADDR_W + 1),
    .DW (DATA_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (bus.Mem2_we_i),
    .waddr_i ({~bank_q, bus.Mem2_addrw_i}),
    .wdata_i (bus.Mem2_data_i),
    .re_i    (ram_re_s),
    .raddr_i ({bank_q, addr_s[EMIF_ADDR_W-1:1]}),
    .rdata_o (ram_rdata_s)
  );

  // EMIF input synchronisers; reset to the idle (high) level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cs_sync_q <= {EMIF_SYNC_STAGES{1'b1}};
      oe_sync_q <= {EMIF_SYNC_STAGES{1'b1}};
      for (int i = 0; i < EMIF_SYNC_STAGES; i++) begin
        addr_sync_q[i] <= {EMIF_ADDR_W{1'b0}};
      end
    end else begin
      cs_sync_q <= {cs_sync_q[EMIF_SYNC_STAGES-2:0], bus.EMIF_cs_i};
      oe_sync_q <= {oe_sync_q[EMIF_SYNC_STAGES-2:0], bus.EMIF_oe_i};
      addr_sync_q[0] <= bus.EMIF_address_i;
      for (int i = 1; i < EMIF_SYNC_STAGES; i++) begin
        addr_sync_q[i] <= addr_sync_q[i-1];
      end
    end
  end

  // state and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      wip_q       <= 1'b0;
      bank_q      <= 1'b0;
      cnt_q       <= 16'd0;
      pend_q      <= 1'b0;
      ovr_q       <= 1'b0;
      hold_q      <= {HOLD_W{1'b0}};
      data_q      <= 32'd0;
      oe_q        <= 1'b0;
      addr_lat_q  <= {EMIF_ADDR_W{1'b0}};
      status_rd_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wip_q       <= bus.WIP_flag_i;
      bank_q      <= bank_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      ovr_q       <= ovr_d;
      hold_q      <= hold_d;
      data_q      <= data_d;
      oe_q        <= oe_d;
      addr_lat_q  <= addr_lat_d;
      status_rd_q <= status_rd_d;
    end
  end

  // read FSM, bank swap and overrun tracking
  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    cnt_d       = cnt_q;
    ovr_d       = ovr_q;
    hold_d      = hold_q;
    data_d      = data_q;
    addr_lat_d  = addr_lat_q;
    status_rd_d = status_rd_q;
    ram_re_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rd_req_s) begin
          state_d = ST_LATCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LATCH: begin
        addr_lat_d = addr_s;
        ram_re_s   = 1'b1;
        state_d    = ST_RAM;
      end
      ST_RAM: begin
        state_d = ST_DRIVE;
        if (addr_lat_q == STATUS_ADDR) begin
          data_d      = status_word(cnt_q, ovr_q, bank_q);
          status_rd_d = 1'b1;
        end else if (!addr_lat_q[0]) begin
          data_d      = word_ext_s[31:0];
          hold_d      = word_ext_s[EXT_W-1:32];
          status_rd_d = 1'b0;
        end else begin
          // high half replays the hold captured by the preceding low-half read
          data_d      = sext_hold(hold_q);
          status_rd_d = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (!rd_req_s) begin
          state_d = ST_IDLE;
          if (status_rd_q) begin
            ovr_d = 1'b0;
          end else begin
            ovr_d = ovr_q;
          end
        end else begin
          state_d = ST_DRIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (do_swap_s) begin
      bank_d = ~bank_q;
      cnt_d  = cnt_q + 16'd1;
    end else begin
      bank_d = bank_q;
      cnt_d  = cnt_q;
    end

    pend_d = fall_s | (pend_q & ~do_swap_s);

    if (rise_s && pend_q) begin
      ovr_d = 1'b1;
    end else begin
      ovr_d = ovr_d;
    end

    oe_d = (state_d == ST_DRIVE);
  end

  assign bus.EMIF_data_o    = data_q;
  assign bus.EMIF_data_oe_o = oe_q;
  assign bank_o             = bank_q;
  assign frame_cnt_o        = cnt_q;
  assign overrun_o          = ovr_q;

endmodule
